// File: rtl/disp_arb_pkg.sv
// ---------------------------------------------------------------------------
// disp_arb_pkg
//   Shared definitions for the display arbiter: FSM state encoding,
//   requester indices and a helper that sizes the down-counters.
// ---------------------------------------------------------------------------
package disp_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int DATA_W    = 16;

    // Requester indices; a higher index means a higher priority.
    localparam int REQ_PASS  = 0;
    localparam int REQ_CNTDN = 1;
    localparam int REQ_ALARM = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Width needed to hold (max count - 1); never less than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/disp_arb_timer.sv
// ---------------------------------------------------------------------------
// disp_arb_timer
//   Loadable down-counter that saturates at zero. One instance times both
//   the hold window and the handover gap; a second one paces the alarm blink
//   when that feature is built in.
//
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (count clears to 0)
//   load_i      load load_val_i this cycle (wins over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one unless already zero
//   zero_o      count is zero
// ---------------------------------------------------------------------------
module disp_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/disp_arbiter.sv
// ---------------------------------------------------------------------------
// disp_arbiter
//   Shares one 4-digit 7-segment controller between passcode entry (0),
//   countdown (1) and alarm code (2). Fixed priority 2 > 1 > 0; an owner keeps
//   the display for at least HOLD_CNT cycles before a higher requester may
//   take it, and every handover inserts GAP_CNT blank cycles.
//
//   Optional feature macro: DISP_BLINK_EN -- while the alarm owns the
//   display, disp_en toggles every BLINK_CNT cycles starting high.
//
//   clk        clock
//   rst        asynchronous active-low reset
//   req        per-requester level request
//   data0..2   BCD digits from each requester
//   grant      one-hot owner (registered)
//   disp_en    display enable (registered)
//   disp_data  digits to the controller (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int HOLD_CNT  = 62_500_000,
    parameter int GAP_CNT   = 50_000,
    parameter int BLINK_CNT = 31_250_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W-1:0]   data2,
    output logic [NUM_REQ-1:0]  grant,
    output logic                disp_en,
    output logic [DATA_W-1:0]   disp_data
);

    localparam int CW = cnt_width(HOLD_CNT, GAP_CNT, BLINK_CNT);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CNT - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CNT - 1);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                disp_en_q;
    logic [DATA_W-1:0]   disp_data_q;

    logic [NUM_REQ-1:0]  win_oh;
    logic                any_req;
    logic                own_req;
    logic                preempt;
    logic                leave_own;
    logic                grant_now;
    logic [DATA_W-1:0]   own_data;

    logic                tmr_load;
    logic [CW-1:0]       tmr_val;
    logic                tmr_dec;
    logic                tmr_zero;

    // ---------------------------------------------------------------------
    // Priority encoder: highest set request wins.
    // ---------------------------------------------------------------------
    always_comb begin
        win_oh = '0;
        if (req[REQ_ALARM])      win_oh[REQ_ALARM] = 1'b1;
        else if (req[REQ_CNTDN]) win_oh[REQ_CNTDN] = 1'b1;
        else if (req[REQ_PASS])  win_oh[REQ_PASS]  = 1'b1;
    end

    assign any_req   = |req;
    assign own_req   = |(req & grant_q);
    // Both vectors are one-hot, so a larger value is a higher priority.
    assign preempt   = tmr_zero && (win_oh > grant_q);
    assign leave_own = !own_req || preempt;
    // A fresh grant is issued straight from IDLE, or at the end of a gap.
    assign grant_now = any_req &&
                       ((state_q == ST_IDLE) || ((state_q == ST_GAP) && tmr_zero));

    always_comb begin
        case (grant_q)
            3'b001:  own_data = data0;
            3'b010:  own_data = data1;
            3'b100:  own_data = data2;
            default: own_data = disp_data_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Shared hold/gap timer control.
    // ---------------------------------------------------------------------
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: tmr_load = any_req;
            ST_OWN: begin
                if (leave_own) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero) tmr_load = any_req;
                else          tmr_dec  = 1'b1;
            end
            default: ;
        endcase
    end

    disp_arb_timer #(.W(CW)) u_tmr (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

`ifdef DISP_BLINK_EN
    localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_CNT - 1);

    logic blink_run;
    logic blink_load;
    logic blink_zero;

    // Blink phase restarts on every new alarm grant; it free-runs while the
    // alarm keeps the display and reloads each time a half-period ends.
    assign blink_run  = (state_q == ST_OWN) && grant_q[REQ_ALARM] && !leave_own;
    assign blink_load = (grant_now && win_oh[REQ_ALARM]) || (blink_run && blink_zero);

    disp_arb_timer #(.W(CW)) u_blink (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (blink_load),
        .load_val_i (BLINK_LD),
        .dec_i      (blink_run),
        .zero_o     (blink_zero)
    );
`endif

    // ---------------------------------------------------------------------
    // Ownership FSM with registered outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            disp_en_q   <= 1'b0;
            disp_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_now) begin
                        state_q   <= ST_OWN;
                        grant_q   <= win_oh;
                        disp_en_q <= 1'b1;
                    end
                end
                ST_OWN: begin
                    disp_data_q <= own_data;
                    if (leave_own) begin
                        state_q   <= ST_GAP;
                        grant_q   <= '0;
                        disp_en_q <= 1'b0;
                    end
`ifdef DISP_BLINK_EN
                    else if (blink_run && blink_zero) begin
                        disp_en_q <= ~disp_en_q;
                    end
`endif
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        if (grant_now) begin
                            state_q   <= ST_OWN;
                            grant_q   <= win_oh;
                            disp_en_q <= 1'b1;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    grant_q   <= '0;
                    disp_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign disp_en   = disp_en_q;
    assign disp_data = disp_data_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter (HOLD_CNT=8, GAP_CNT=2, BLINK_CNT=4).
module tb_disp_arbiter;

    localparam int HOLD  = 8;
    localparam int GAP   = 2;
    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] d0, d1, d2;
    logic [2:0]  grant;
    logic        disp_en;
    logic [15:0] disp_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 = none), cycles since grant,
    // gap flag and cycles spent in the gap.
    int          m_own;
    bit          m_gap;
    int          m_age;
    int          m_gage;
    logic [15:0] m_data;

    disp_arbiter #(
        .HOLD_CNT  (HOLD),
        .GAP_CNT   (GAP),
        .BLINK_CNT (BLINK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (d0),
        .data1     (d1),
        .data2     (d2),
        .grant     (grant),
        .disp_en   (disp_en),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int top_of(input logic [2:0] r);
        if (r[2]) return 2;
        if (r[1]) return 1;
        if (r[0]) return 0;
        return -1;
    endfunction

    task automatic m_reset();
        m_own  = -1;
        m_gap  = 0;
        m_age  = 0;
        m_gage = 0;
        m_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        if (!rst) begin
            m_reset();
        end else if (m_own >= 0) begin
            m_data = (m_own == 0) ? d0 : (m_own == 1) ? d1 : d2;
            if (!req[m_own] || (m_age >= HOLD - 1 && top_of(req) > m_own)) begin
                m_own  = -1;
                m_gap  = 1;
                m_gage = 0;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            if (m_gage >= GAP - 1) begin
                m_gap = 0;
                if (req != 3'b000) begin
                    m_own = top_of(req);
                    m_age = 0;
                end
            end else begin
                m_gage++;
            end
        end else if (req != 3'b000) begin
            m_own = top_of(req);
            m_age = 0;
        end
    endtask

    task automatic check_outputs();
        logic [2:0] g;
        logic       en;
        g  = 3'b000;
        en = 1'b0;
        if (m_own >= 0) begin
            g[m_own] = 1'b1;
            en       = 1'b1;
`ifdef DISP_BLINK_EN
            if (m_own == 2) en = ((m_age / BLINK) % 2) == 0;
`endif
        end
        chk("grant", 32'(grant), 32'(g));
        chk("disp_en", 32'(disp_en), 32'(en));
        chk("disp_data", 32'(disp_data), 32'(m_data));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Assert reset away from any edge and check outputs clear at once.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_en"}, 32'(disp_en), 32'h0);
        chk({tag, "_data"}, 32'(disp_data), 32'h0);
        m_reset();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        m_reset();
        rst = 1'b0;
        req = 3'b000;
        d0  = '0;
        d1  = 16'h1234;
        d2  = 16'h9999;

        // Reset, then idle for 20 cycles.
        repeat (3) cycle();
        rst = 1'b1;
        repeat (20) cycle();

        // First grant and 1-cycle data latency.
        d0  = 16'h2580;
        req = 3'b001;
        cycle();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_en", 32'(disp_en), 32'h1);
        cycle();
        chk("first_data", 32'(disp_data), 32'h2580);

        // Higher request 3 cycles into the hold: waits for hold expiry + gap.
        repeat (2) cycle();
        req = 3'b011;
        repeat (14) cycle();
        chk("preempt_end", 32'(grant), 32'h2);

        // Alarm owner is never preempted by lower requests.
        req = 3'b111;
        repeat (30) cycle();
        chk("alarm_hold", 32'(grant), 32'h4);
        req = 3'b011;
        repeat (3) cycle();
        chk("fallback", 32'(grant), 32'h2);

        // Owner drop coinciding with a higher request: one gap, then alarm.
        req = 3'b000;
        repeat (4) cycle();
        req = 3'b001;
        repeat (3) cycle();
        req = 3'b100;
        cycle();
        req = 3'b110;
        cycle();
        req = 3'b100;
        repeat (2) cycle();
        chk("handover", 32'(grant), 32'h4);

        // A request pulse confined to the gap is not granted.
        req = 3'b000;
        cycle();
        req = 3'b010;
        cycle();
        req = 3'b000;
        repeat (3) cycle();
        chk("gap_pulse", 32'(grant), 32'h0);

        // Async reset mid-GAP and mid-OWN.
        req = 3'b100;
        repeat (3) cycle();
        req = 3'b000;
        cycle();
        async_reset("rst_gap");
        d1  = 16'h4321;
        req = 3'b010;
        repeat (3) cycle();
        async_reset("rst_own");

        // Randomized traffic with persistent request levels.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            if ($urandom_range(3) == 0) d0 = 16'($urandom);
            if ($urandom_range(3) == 0) d1 = 16'($urandom);
            if ($urandom_range(3) == 0) d2 = 16'($urandom);
            if ($urandom_range(499) == 0) async_reset("rand_rst");
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the single 4-digit 7-segment display controller between three requesters: passcode entry (0), countdown (1) and alarm/error code (2).
- Sits between the detonator FSM/timer logic and the display controller. Drives the controller's enable and 16-bit BCD data.
- Fixed priority with a minimum-hold window, plus a blanking gap on every handover to suppress ghosting.

Parameters:
- HOLD_CNT, 62_500_000: minimum cycles an owner keeps the display before a higher-priority requester may preempt it. Must be ≥1.
- GAP_CNT, 50_000: blank cycles inserted on every handover. Must be ≥1.
- BLINK_CNT, 31_250_000: half-period in cycles of the alarm blink. Used only with DISP_BLINK_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- req  input  3  request per requester; level, held while display wanted
- data0  input  16  BCD digits from requester 0
- data1  input  16  BCD digits from requester 1
- data2  input  16  BCD digits from requester 2
- grant  output  3  one-hot current owner, registered
- disp_en  output  1  display controller enable, registered
- disp_data  output  16  data to display controller, registered

Behaviour:
- Reset (rst low, async): state IDLE; grant=0; disp_en=0; disp_data=0; timer=0.
- Priority: req[2] > req[1] > req[0]. The winner is the highest set bit.
- States and transitions:
  - IDLE: grant=0, disp_en=0.
    - If any req is sampled high at edge N, the state becomes OWN at edge N+1, with grant=winner and disp_en=1.
    - The hold timer loads HOLD_CNT-1 at that same edge. No gap is inserted from IDLE.
  - OWN: disp_data <= data of owner, every cycle, so there is 1-cycle latency from dataX to disp_data.
    - Timer decrements to 0 and saturates there.
    - Owner req low → GAP. This happens immediately, regardless of the timer.
    - Timer==0 and a higher-priority req is high → GAP (preemption).
    - A lower-priority req never preempts.
  - GAP: grant=0, disp_en=0, disp_data holds its last value. Timer loads GAP_CNT-1 on entry and counts down.
    - At timer==0 the winner is re-evaluated from req at that edge.
    - If a winner exists → OWN (timer reloads HOLD_CNT-1). Otherwise → IDLE.
- Simultaneous events:
  - Owner drops while a higher request rises in the same cycle → a single GAP, then the higher request wins.
  - A requester that drops during GAP is not granted.
  - A requester that rises during GAP competes at GAP end.
- Invariants: grant is always one-hot or zero; disp_en == |grant, except under DISP_BLINK_EN as below.
- Reset asserted mid-OWN or mid-GAP: outputs clear asynchronously, and operation restarts from IDLE.
- Counter widths: $clog2 of the max of HOLD_CNT, GAP_CNT and BLINK_CNT. No wrap; the count saturates at 0.

Optional Feature:
- DISP_BLINK_EN defined:
  - While grant[2] is set, disp_en toggles every BLINK_CNT cycles, starting high at grant.
  - The blink counter resets on every new grant of requester 2.
  - disp_data is unaffected.
- Not defined: disp_en == |grant always. No blink logic and no BLINK_CNT counter are synthesized.

Decomposition:
- Shared package disp_arb_pkg:
  - state encoding IDLE/OWN/GAP
  - requester indices REQ_PASS=0, REQ_CNTDN=1, REQ_ALARM=2
  - NUM_REQ=3
- Sub-module disp_arb_timer: loadable saturating down-counter with a zero flag. It is shared by the HOLD and GAP phases.
- The priority encoder stays inline.

Test Plan (bench params HOLD_CNT=8, GAP_CNT=2):
- Reset release, req=000 → grant=000, disp_en=0, disp_data=0000 held for 20 cycles.
- req=001, data0=16'h2580 at edge N → grant=001 and disp_en=1 at N+1; disp_data=2580 at N+2.
- Owner 001, req[1] rises 3 cycles after grant → no switch until hold expires (8 cycles after grant). Then 2 cycles of grant=000/disp_en=0, then grant=010.
- Owner 100 holding, req[0] and req[1] high → grant stays 100 indefinitely. req[2] drops → 2-cycle gap → grant=010.
- In one cycle, owner 001 drops req and req[2] rises → exactly one 2-cycle gap → grant=100. A req[1] pulse confined to the gap is never granted.
- rst low asynchronously mid-GAP and mid-OWN → grant, disp_en and disp_data read 0 before the next clk edge.
- (DISP_BLINK_EN, BLINK_CNT=4) grant=100 → disp_en pattern 1111 0000 1111 … while grant stays 100.
